instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch front end that sits on the read side of the 16×8 instruction memory. It drives the memory's `pc` address, captures the returned instruction byte, and hands instructions to decode over a valid/ready handshake. A small skid buffer absorbs decode backpressure, and a redirect port restarts fetch at a new address with full flush of stale words.

## Interface
- `PC_WIDTH`, 4, address width; the address space is 2^PC_WIDTH words.
- `DATA_WIDTH`, 8, instruction word width.
- `BUF_DEPTH`, 2, instruction buffer entries (≥2).
- `RESET_PC`, 0, fetch address after reset.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: one clock; reset is synchronous and active-low.
- `enable` input 1: run request; fetch issues only while high.
- `redirect_valid` input 1: one-cycle pulse; restart fetch at `redirect_pc`.
- `redirect_pc` input PC_WIDTH: new fetch address.
- `pc` output PC_WIDTH: registered address to instruction memory.
- `mem_data` input DATA_WIDTH: word returned by instruction memory.
- `instr_valid` output 1: buffer head holds a valid instruction.
- `instr_data` output DATA_WIDTH: head instruction word.
- `instr_pc` output PC_WIDTH: address the head word was fetched from.
- `instr_ready` input 1: decode accepts the head this cycle.
- `fetching` output 1: high in state RUN.

## Operation
- **Memory contract:** `mem_data` in cycle t+1 is the word at the address `pc` held in cycle t, giving a one-cycle read latency.
- **States:** IDLE and RUN. IDLE→RUN when `enable`=1 at the edge. RUN→IDLE when `enable`=0. `fetching` = (state==RUN).
- **Issue:** occurs in cycle t iff all of the following hold:
  - state is RUN;
  - `redirect_valid`=0;
  - count + inflight − pop < BUF_DEPTH, where pop = `instr_valid` & `instr_ready`.
- **On issue:**
  - inflight←1;
  - inflight_pc←`pc`;
  - `pc`←`pc`+1 modulo 2^PC_WIDTH, so 15 wraps to 0.
- **Capture:** if inflight=1 in cycle t+1, {`mem_data`, inflight_pc} is pushed into the buffer at the end of t+1, and inflight clears unless a new issue occurs.
- **Buffer:**
  - in-order FIFO;
  - `instr_valid` = count≠0;
  - `instr_data`/`instr_pc` show the head entry;
  - pop when `instr_valid` & `instr_ready`;
  - simultaneous push and pop keeps count unchanged.
  - The issue rule guarantees a push never overflows the buffer.
- **enable low:** no new issues; the in-flight word is still captured; the buffer keeps draining normally.
- **Redirect** (accepted in any state, has priority over everything):
  - buffer cleared (count←0);
  - inflight←0, so the word arriving next cycle is discarded;
  - `pc`←`redirect_pc`;
  - no issue and no pop that cycle.
  - Fetch resumes from `redirect_pc` the following cycle if state is RUN.
- **Reset values:** `pc`=RESET_PC, `instr_valid`=0, `instr_data`=0, `instr_pc`=0, `fetching`=0, state IDLE, count=0, inflight=0.

## Timing
- `enable` rises in cycle 0 → RUN in cycle 1 → issue at `pc`=RESET_PC in cycle 1 → capture in cycle 2 → `instr_valid`=1 in cycle 3. The first-instruction latency is 3 cycles.
- Steady state with `instr_ready` held high: one instruction per cycle (count 1, inflight 1, pop 1).
- Backpressure: at most BUF_DEPTH words are held, counting in-flight. `pc` stops advancing when the limit is reached and resumes the cycle after a pop frees space.
- Redirect in cycle t: `instr_valid`=0 in t+1; the first word from `redirect_pc` becomes valid in t+3 (RUN assumed).
- Reset mid-operation: at the next edge with `rst_n`=0, all state returns to the reset values. The in-flight word and buffered words are dropped.
- Outputs are registered or derived from registered state only. There is no combinational path from `instr_ready` to `instr_valid`.

## Test plan
- **Reset:** `rst_n`=0 for 2 cycles with `enable`=1 and `redirect_valid`=1 → `pc`=0, `instr_valid`=0, `fetching`=0. After release, first `instr_valid` appears 3 cycles after RUN entry.
- **Streaming and wrap:** memory mem[i]=0x10+i, `instr_ready`=1 → `instr_pc` 0,1,…,15,0,1 and `instr_data` 0x10…0x1F,0x10, one per cycle with no bubbles after the first.
- **Backpressure:** drop `instr_ready` for 5 cycles mid-stream → exactly 2 entries held, `pc` frozen. On release, delivery continues in order with no loss or duplication.
- **Redirect with full buffer:** assert `redirect_valid` with `redirect_pc`=9 → `instr_valid`=0 next cycle, then `instr_pc`=9 with `instr_data`=0x19. No stale word, including the in-flight one, is ever presented.
- **Disable mid-stream:** `enable`=0 → the in-flight word is still delivered, `pc` holds, `fetching`=0. Re-enable → fetch resumes at the held `pc`.
- **Simultaneous redirect and pop:** `instr_ready`=1 in the redirect cycle → the head is not counted as consumed by decode logic, and the buffer is empty next cycle.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: drives the instruction memory address, captures returned words
// into a small in-order buffer and presents them to decode over a valid/ready handshake.
module instr_fetch_unit #(
  parameter int                  PC_WIDTH   = 4,
  parameter int                  DATA_WIDTH = 8,
  parameter int                  BUF_DEPTH  = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic [PC_WIDTH-1:0]   pc,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [PC_WIDTH-1:0]   instr_pc,
  input  logic                  instr_ready,
  output logic                  fetching
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  typedef enum logic {IDLE, RUN} state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [PC_WIDTH-1:0]   addr;
  } entry_t;

  state_e              state_q;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                inflight_q, inflight_d;
  logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  entry_t              buf_q [BUF_DEPTH];
  entry_t              head;

  logic                pop;
  logic                push;
  logic                issue;
  logic [CNT_W:0]      occupancy;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Redirect masks both ends of the buffer: the head is not consumed and the arriving word is stale.
  assign pop  = instr_valid & instr_ready & ~redirect_valid;
  assign push = inflight_q & ~redirect_valid;

  // Words held or on their way, after this cycle's pop; issue only if one more still fits.
  assign occupancy = (CNT_W+1)'(count_q) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
  assign issue     = (state_q == RUN) & ~redirect_valid & (occupancy < (CNT_W+1)'(BUF_DEPTH));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    if (redirect_valid) begin
      pc_d     = redirect_pc;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (issue) begin
        pc_d          = pc_q + PC_WIDTH'(1);
        inflight_pc_d = pc_q;
      end
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      case (state_q)
        IDLE:    if (enable)  state_q <= RUN;
        RUN:     if (!enable) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // NOTE: buffer storage is not reset; count_q gates validity and empty entries are never shown.
  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr_q] <= '{data: mem_data, addr: inflight_pc_q};
  end

  assign head        = buf_q[rd_ptr_q];
  assign pc          = pc_q;
  assign fetching    = (state_q == RUN);
  assign instr_valid = (count_q != '0);
  assign instr_data  = instr_valid ? head.data : '0;
  assign instr_pc    = instr_valid ? head.addr : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized run, all
// checked against an in-order delivery model (next expected address, run flag).
module tb_instr_fetch_unit;

  localparam int PW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          redirect_valid;
  logic [PW-1:0] redirect_pc;
  logic [PW-1:0] pc;
  logic [DW-1:0] mem_data;
  logic          instr_valid;
  logic [DW-1:0] instr_data;
  logic [PW-1:0] instr_pc;
  logic          instr_ready;
  logic          fetching;

  logic [DW-1:0] imem [16];

  // Reference model: address of the next word decode should see, and the expected run state.
  logic [PW-1:0] exp_head;
  logic          exp_run;

  int pass_cnt  = 0;
  int total_cnt = 0;

  instr_fetch_unit #(
    .PC_WIDTH  (PW),
    .DATA_WIDTH(DW),
    .BUF_DEPTH (DEPTH),
    .RESET_PC  ('0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .pc            (pc),
    .mem_data      (mem_data),
    .instr_valid   (instr_valid),
    .instr_data    (instr_data),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .fetching      (fetching)
  );

  always #5 clk = ~clk;

  // One-cycle read latency instruction memory.
  always @(posedge clk) mem_data <= imem[pc];

  // Update the model from this cycle's inputs/outputs, then advance one clock and settle.
  task automatic tick();
    if (!rst_n) begin
      exp_head = '0;
      exp_run  = 1'b0;
    end else begin
      if (redirect_valid)                exp_head = redirect_pc;
      else if (instr_valid && instr_ready) exp_head = exp_head + PW'(1);
      exp_run = enable;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] seq_word(input logic [PW-1:0] a);
    return 8'h10 + DW'(a);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; redirect_valid = 1'b1; redirect_pc = 4'd5; instr_ready = 1'b1;
    tick();
    tick();
    total_cnt++; if (pc !== 4'd0) $display("FAIL reset_pc got=%0h exp=0", pc); else pass_cnt++;
    total_cnt++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", instr_valid); else pass_cnt++;
    total_cnt++; if (fetching !== 1'b0) $display("FAIL reset_fetching got=%b exp=0", fetching); else pass_cnt++;
    total_cnt++; if (instr_data !== 8'h00) $display("FAIL reset_data got=%0h exp=0", instr_data); else pass_cnt++;
    total_cnt++; if (instr_pc !== 4'd0) $display("FAIL reset_instr_pc got=%0h exp=0", instr_pc); else pass_cnt++;
    rst_n = 1'b1; redirect_valid = 1'b0;
    tick();
    total_cnt++; if (fetching !== 1'b1) $display("FAIL run_entry got=%b exp=1", fetching); else pass_cnt++;
    total_cnt++; if (instr_valid !== 1'b0) $display("FAIL lat_cyc1 got=%b exp=0", instr_valid); else pass_cnt++;
    tick();
    total_cnt++; if (instr_valid !== 1'b0) $display("FAIL lat_cyc2 got=%b exp=0", instr_valid); else pass_cnt++;
    tick();
    total_cnt++; if (instr_valid !== 1'b1) $display("FAIL lat_cyc3 got=%b exp=1", instr_valid); else pass_cnt++;
    total_cnt++; if (instr_pc !== 4'd0) $display("FAIL first_pc got=%0h exp=0", instr_pc); else pass_cnt++;
    total_cnt++; if (instr_data !== 8'h10) $display("FAIL first_data got=%0h exp=10", instr_data); else pass_cnt++;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 20; i++) begin
      total_cnt++; if (instr_valid !== 1'b1) $display("FAIL stream_valid cyc=%0d got=%b exp=1", i, instr_valid); else pass_cnt++;
      total_cnt++; if (instr_pc !== exp_head) $display("FAIL stream_pc cyc=%0d got=%0h exp=%0h", i, instr_pc, exp_head); else pass_cnt++;
      total_cnt++; if (instr_data !== seq_word(exp_head)) $display("FAIL stream_data cyc=%0d got=%0h exp=%0h", i, instr_data, seq_word(exp_head)); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] held;
    instr_ready = 1'b0;
    tick();
    held = pc;
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (pc !== held) $display("FAIL bp_pc_frozen cyc=%0d got=%0h exp=%0h", i, pc, held); else pass_cnt++;
      total_cnt++; if (PW'(pc - exp_head) !== PW'(DEPTH)) $display("FAIL bp_held cyc=%0d got=%0d exp=%0d", i, PW'(pc - exp_head), DEPTH); else pass_cnt++;
      total_cnt++; if (instr_valid !== 1'b1 || instr_pc !== exp_head) $display("FAIL bp_head cyc=%0d got=%b/%0h exp=1/%0h", i, instr_valid, instr_pc, exp_head); else pass_cnt++;
      tick();
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      total_cnt++; if (instr_valid !== 1'b1) $display("FAIL bp_release_valid cyc=%0d got=%b exp=1", i, instr_valid); else pass_cnt++;
      total_cnt++; if (instr_pc !== exp_head || instr_data !== seq_word(exp_head)) $display("FAIL bp_release_word cyc=%0d got=%0h:%0h exp=%0h:%0h", i, instr_pc, instr_data, exp_head, seq_word(exp_head)); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_redirect();
    instr_ready = 1'b0;
    tick(); tick(); tick();
    total_cnt++; if (PW'(pc - exp_head) !== PW'(DEPTH)) $display("FAIL redir_full got=%0d exp=%0d", PW'(pc - exp_head), DEPTH); else pass_cnt++;
    redirect_valid = 1'b1; redirect_pc = 4'd9;
    tick();
    redirect_valid = 1'b0; instr_ready = 1'b1;
    total_cnt++; if (instr_valid !== 1'b0) $display("FAIL redir_t1_valid got=%b exp=0", instr_valid); else pass_cnt++;
    total_cnt++; if (pc !== 4'd9) $display("FAIL redir_t1_pc got=%0h exp=9", pc); else pass_cnt++;
    tick();
    total_cnt++; if (instr_valid !== 1'b0) $display("FAIL redir_t2_valid got=%b exp=0", instr_valid); else pass_cnt++;
    tick();
    total_cnt++; if (instr_valid !== 1'b1) $display("FAIL redir_t3_valid got=%b exp=1", instr_valid); else pass_cnt++;
    total_cnt++; if (instr_pc !== 4'd9 || instr_data !== 8'h19) $display("FAIL redir_t3_word got=%0h:%0h exp=9:19", instr_pc, instr_data); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++; if (instr_valid !== 1'b1 || instr_pc !== exp_head || instr_data !== seq_word(exp_head)) $display("FAIL redir_follow cyc=%0d got=%b %0h:%0h exp=1 %0h:%0h", i, instr_valid, instr_pc, instr_data, exp_head, seq_word(exp_head)); else pass_cnt++;
    end
  endtask

  task automatic test_redirect_pop();
    total_cnt++; if (instr_valid !== 1'b1) $display("FAIL rpop_pre_valid got=%b exp=1", instr_valid); else pass_cnt++;
    redirect_valid = 1'b1; redirect_pc = 4'd3; instr_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    total_cnt++; if (instr_valid !== 1'b0) $display("FAIL rpop_t1_valid got=%b exp=0", instr_valid); else pass_cnt++;
    tick();
    total_cnt++; if (instr_valid !== 1'b0) $display("FAIL rpop_t2_valid got=%b exp=0", instr_valid); else pass_cnt++;
    tick();
    total_cnt++; if (instr_valid !== 1'b1 || instr_pc !== 4'd3 || instr_data !== 8'h13) $display("FAIL rpop_t3_word got=%b %0h:%0h exp=1 3:13", instr_valid, instr_pc, instr_data); else pass_cnt++;
  endtask

  task automatic test_disable();
    logic [PW-1:0] held;
    tick(); tick();
    enable = 1'b0;
    tick();
    held = pc;
    for (int i = 0; i < 5; i++) begin
      total_cnt++; if (fetching !== 1'b0) $display("FAIL dis_fetching cyc=%0d got=%b exp=0", i, fetching); else pass_cnt++;
      total_cnt++; if (pc !== held) $display("FAIL dis_pc_hold cyc=%0d got=%0h exp=%0h", i, pc, held); else pass_cnt++;
      if (instr_valid === 1'b1) begin
        total_cnt++; if (instr_pc !== exp_head || instr_data !== seq_word(exp_head)) $display("FAIL dis_drain cyc=%0d got=%0h:%0h exp=%0h:%0h", i, instr_pc, instr_data, exp_head, seq_word(exp_head)); else pass_cnt++;
      end
      tick();
    end
    total_cnt++; if (instr_valid !== 1'b0) $display("FAIL dis_drained got=%b exp=0", instr_valid); else pass_cnt++;
    total_cnt++; if (exp_head !== held) $display("FAIL dis_all_delivered got=%0h exp=%0h", exp_head, held); else pass_cnt++;
    enable = 1'b1;
    tick();
    total_cnt++; if (fetching !== 1'b1 || instr_valid !== 1'b0) $display("FAIL reen_e1 got=%b/%b exp=1/0", fetching, instr_valid); else pass_cnt++;
    tick();
    total_cnt++; if (instr_valid !== 1'b0) $display("FAIL reen_e2 got=%b exp=0", instr_valid); else pass_cnt++;
    tick();
    total_cnt++; if (instr_valid !== 1'b1 || instr_pc !== held || instr_data !== seq_word(held)) $display("FAIL reen_e3 got=%b %0h:%0h exp=1 %0h:%0h", instr_valid, instr_pc, instr_data, held, seq_word(held)); else pass_cnt++;
  endtask

  task automatic test_random();
    logic prev_redirect;
    int   delivered;
    int   errs;
    rst_n = 1'b0; redirect_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) imem[i] = DW'($urandom);
    prev_redirect = 1'b0;
    delivered = 0;
    errs = 0;
    for (int c = 0; c < 800; c++) begin
      enable         = ($urandom_range(0, 9) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = PW'($urandom);
      instr_ready    = ($urandom_range(0, 3) != 0);
      total_cnt++;
      if (fetching !== exp_run) begin $display("FAIL rnd_fetching cyc=%0d got=%b exp=%b", c, fetching, exp_run); errs++; end
      else pass_cnt++;
      total_cnt++;
      if (PW'(pc - exp_head) > PW'(DEPTH)) begin $display("FAIL rnd_capacity cyc=%0d got=%0d exp<=%0d", c, PW'(pc - exp_head), DEPTH); errs++; end
      else pass_cnt++;
      if (prev_redirect) begin
        total_cnt++;
        if (instr_valid !== 1'b0) begin $display("FAIL rnd_redir_flush cyc=%0d got=%b exp=0", c, instr_valid); errs++; end
        else pass_cnt++;
      end
      if (instr_valid === 1'b1) begin
        total_cnt++;
        if (instr_pc !== exp_head || instr_data !== imem[exp_head]) begin
          $display("FAIL rnd_word cyc=%0d got=%0h:%0h exp=%0h:%0h", c, instr_pc, instr_data, exp_head, imem[exp_head]);
          errs++;
        end else pass_cnt++;
        if (instr_ready && !redirect_valid) delivered++;
      end
      if (errs > 20) break;
      prev_redirect = redirect_valid;
      tick();
    end
    total_cnt++; if (delivered < 100) $display("FAIL rnd_throughput got=%0d exp>=100", delivered); else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) imem[i] = 8'h10 + DW'(i);
    rst_n = 1'b0; enable = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    exp_head = '0; exp_run = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_disable();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
